// File: rtl/tournament_chooser_table.sv
// Fetch-side tournament chooser: PC-indexed 2-bit selector table, final prediction mux and speculative GHR.
// Optional: define TOURNAMENT_BYPASS_EN for write-through of a same-index update into the lookup result.
module tournament_chooser_table #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned GHR_BITS   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lookup_en,
   input  logic                lookup_stall,
   input  logic [31:0]         lookup_pc,
   output logic                pred_valid,
   output logic [1:0]          pred_sel,
   input  logic [1:0]          pred_local,
   input  logic [1:0]          pred_global,
   output logic                pred_taken,
   input  logic                spec_shift_en,
   input  logic                spec_taken,
   input  logic                load_prediction,
   input  logic [31:0]         update_pc,
   input  logic [1:0]          update_sel,
   input  logic                repair_en,
   input  logic [GHR_BITS-1:0] repair_ghr,
   input  logic                repair_taken,
   output logic [GHR_BITS-1:0] ghr
);

   localparam int unsigned DEPTH = 1 << INDEX_BITS;
   localparam logic [1:0]  SEL_WEAK_LOCAL = 2'b01;

   logic [1:0]            table_q [DEPTH];
   logic [INDEX_BITS-1:0] lookup_idx;
   logic [INDEX_BITS-1:0] update_idx;
   logic [1:0]            read_sel_c;
   logic                  unused_bits;

   assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
   assign update_idx = update_pc[INDEX_BITS+1:2];

   // Bits above the index are deliberately ignored: untagged table, aliasing is intended.
   assign unused_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                          update_pc[31:INDEX_BITS+2], update_pc[1:0],
                          pred_local[0], pred_global[0], repair_ghr[GHR_BITS-1]};

`ifdef TOURNAMENT_BYPASS_EN
   assign read_sel_c = (load_prediction && (update_idx == lookup_idx)) ? update_sel
                                                                      : table_q[lookup_idx];
`else
   assign read_sel_c = table_q[lookup_idx];
`endif

   // Chooser table: single write port, never blocked by fetch stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            table_q[i] <= SEL_WEAK_LOCAL;
         end
      end else if (load_prediction) begin
         table_q[update_idx] <= update_sel;
      end
   end

   // Registered lookup; stall freezes both outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_valid <= 1'b0;
         pred_sel   <= SEL_WEAK_LOCAL;
      end else if (!lookup_stall) begin
         pred_valid <= lookup_en;
         if (lookup_en) begin
            pred_sel <= read_sel_c;
         end
      end
   end

   assign pred_taken = pred_valid & (pred_sel[1] ? pred_global[1] : pred_local[1]);

   // Speculative history; a repair overrides any same-cycle speculative shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr <= '0;
      end else if (repair_en) begin
         ghr <= {repair_ghr[GHR_BITS-2:0], repair_taken};
      end else if (spec_shift_en) begin
         ghr <= {ghr[GHR_BITS-2:0], spec_taken};
      end
   end

endmodule

// File: tb/tb_tournament_chooser_table.sv
// Scoreboard bench for tournament_chooser_table: per-cycle expectations from a behavioural model,
// plus directed scenarios and randomized traffic.
module tb_tournament_chooser_table;

   localparam int unsigned INDEX_BITS = 6;
   localparam int unsigned GHR_BITS   = 8;
   localparam int unsigned DEPTH      = 1 << INDEX_BITS;

   logic                clk = 1'b0;
   logic                rst;
   logic                lookup_en, lookup_stall;
   logic [31:0]         lookup_pc;
   logic                pred_valid;
   logic [1:0]          pred_sel;
   logic [1:0]          pred_local, pred_global;
   logic                pred_taken;
   logic                spec_shift_en, spec_taken;
   logic                load_prediction;
   logic [31:0]         update_pc;
   logic [1:0]          update_sel;
   logic                repair_en;
   logic [GHR_BITS-1:0] repair_ghr;
   logic                repair_taken;
   logic [GHR_BITS-1:0] ghr;

   tournament_chooser_table #(.INDEX_BITS(INDEX_BITS), .GHR_BITS(GHR_BITS)) dut (
      .clk(clk), .rst(rst),
      .lookup_en(lookup_en), .lookup_stall(lookup_stall), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid), .pred_sel(pred_sel),
      .pred_local(pred_local), .pred_global(pred_global), .pred_taken(pred_taken),
      .spec_shift_en(spec_shift_en), .spec_taken(spec_taken),
      .load_prediction(load_prediction), .update_pc(update_pc), .update_sel(update_sel),
      .repair_en(repair_en), .repair_ghr(repair_ghr), .repair_taken(repair_taken),
      .ghr(ghr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       valid;
      logic [1:0] sel;
      logic       taken;
      logic [7:0] ghr;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference state: plain arrays and integer arithmetic.
   logic [1:0] m_tab [DEPTH];
   logic       m_valid;
   logic [1:0] m_sel;
   int         m_ghr;
   bit         written [DEPTH];

`ifdef TOURNAMENT_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_tab[i] = 2'b01;
      m_valid = 1'b0;
      m_sel   = 2'b01;
      m_ghr   = 0;
   endtask

   task automatic idle();
      lookup_en = 0; lookup_stall = 0; lookup_pc = '0;
      pred_local = 2'b00; pred_global = 2'b00;
      spec_shift_en = 0; spec_taken = 0;
      load_prediction = 0; update_pc = '0; update_sel = 2'b00;
      repair_en = 0; repair_ghr = '0; repair_taken = 0;
   endtask

   // Advance the model by one clock using the currently driven inputs, queue the expectation,
   // then let the DUT take the edge. Returns at the following negedge.
   task automatic step();
      exp_t       e;
      int         li, ui;
      logic [1:0] rd;
      li = int'(lookup_pc / 4) % DEPTH;
      ui = int'(update_pc / 4) % DEPTH;
      rd = m_tab[li];
      if (BYPASS && load_prediction && (ui == li)) rd = update_sel;
      if (!lookup_stall) begin
         m_valid = lookup_en;
         if (lookup_en) m_sel = rd;
      end
      if (load_prediction) begin
         m_tab[ui]   = update_sel;
         written[ui] = 1'b1;
      end
      if (repair_en)          m_ghr = (int'(repair_ghr) * 2 + int'(repair_taken)) % 256;
      else if (spec_shift_en) m_ghr = (m_ghr * 2 + int'(spec_taken)) % 256;
      e.valid = m_valid;
      e.sel   = m_sel;
      e.taken = m_valid && (m_sel >= 2'd2 ? pred_global >= 2'd2 : pred_local >= 2'd2);
      e.ghr   = 8'(m_ghr);
      q_exp.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: every cycle with a queued expectation is compared shortly after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk("sb_valid", 32'(pred_valid), 32'(e.valid));
            chk("sb_sel",   32'(pred_sel),   32'(e.sel));
            chk("sb_taken", 32'(pred_taken), 32'(e.taken));
            chk("sb_ghr",   32'(ghr),        32'(e.ghr));
         end
      end
   end

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
      #3;
      chk("rst_valid", 32'(pred_valid), 32'h0);
      chk("rst_sel",   32'(pred_sel),   32'h1);
      chk("rst_ghr",   32'(ghr),        32'h0);
      chk("rst_taken", 32'(pred_taken), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // First lookup after reset: weak local, local counter says taken.
      lookup_en = 1; lookup_pc = 32'h40; pred_local = 2'b10; pred_global = 2'b00;
      step();
      chk("lk0_valid", 32'(pred_valid), 32'h1);
      chk("lk0_sel",   32'(pred_sel),   32'h1);
      chk("lk0_taken", 32'(pred_taken), 32'h1);

      idle(); load_prediction = 1; update_pc = 32'h40; update_sel = 2'b11;
      step();
      idle(); lookup_en = 1; lookup_pc = 32'h40; pred_global = 2'b10; pred_local = 2'b00;
      step();
      chk("upd_sel",   32'(pred_sel),   32'h3);
      chk("upd_taken", 32'(pred_taken), 32'h1);
      lookup_pc = 32'h140;
      step();
      chk("alias_sel", 32'(pred_sel), 32'h3);

      // Same-cycle update and lookup to one index.
      idle(); lookup_en = 1; lookup_pc = 32'h80; load_prediction = 1; update_pc = 32'h80; update_sel = 2'b10;
      step();
      chk("same_sel", 32'(pred_sel), BYPASS ? 32'h2 : 32'h1);
      idle(); lookup_en = 1; lookup_pc = 32'h80;
      step();
      chk("same_next_sel", 32'(pred_sel), 32'h2);

      // Stall freezes outputs; a write during the stall lands.
      lookup_pc = 32'h40;
      step();
      for (int i = 0; i < 3; i++) begin
         idle(); lookup_stall = 1; lookup_en = i[0]; lookup_pc = 32'h80 + 32'(i * 4);
         if (i == 0) begin load_prediction = 1; update_pc = 32'hc0; update_sel = 2'b00; end
         step();
         chk("stall_valid", 32'(pred_valid), 32'h1);
         chk("stall_sel",   32'(pred_sel),   32'h3);
      end
      idle(); lookup_en = 1; lookup_pc = 32'hc0;
      step();
      chk("post_stall_sel", 32'(pred_sel), 32'h0);

      // GHR shift and repair priority.
      idle();
      spec_shift_en = 1; spec_taken = 1; step();
      spec_taken = 1; step();
      spec_taken = 0; step();
      chk("ghr_shift", 32'(ghr), 32'h06);
      spec_taken = 1; repair_en = 1; repair_ghr = 8'hA5; repair_taken = 0;
      step();
      chk("ghr_repair", 32'(ghr), 32'h4A);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         lookup_en       = ($urandom_range(0, 3) != 0);
         lookup_stall    = ($urandom_range(0, 7) == 0);
         lookup_pc       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15) * 4);
         pred_local      = 2'($urandom);
         pred_global     = 2'($urandom);
         load_prediction = ($urandom_range(0, 2) == 0);
         update_pc       = ($urandom_range(0, 2) == 0) ? lookup_pc : 32'($urandom_range(0, 15) * 4);
         update_sel      = 2'($urandom);
         spec_shift_en   = ($urandom_range(0, 1) != 0);
         spec_taken      = 1'($urandom);
         repair_en       = ($urandom_range(0, 9) == 0);
         repair_ghr      = 8'($urandom);
         repair_taken    = 1'($urandom);
         step();
      end

      // Asynchronous reset in mid-cycle with a lookup pending.
      idle(); lookup_en = 1; lookup_pc = 32'h44; spec_shift_en = 1; spec_taken = 1;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ghr",   32'(ghr),        32'h0);
      chk("arst_valid", 32'(pred_valid), 32'h0);
      model_reset();
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      chk("post_rst_valid", 32'(pred_valid), 32'h0);
      for (int i = 0; i < DEPTH; i++) begin
         if (written[i]) begin
            lookup_en = 1; lookup_pc = 32'(i * 4);
            step();
            chk("post_rst_entry", 32'(pred_sel), 32'h1);
         end
      end
      idle();
      step();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tournament_chooser_table.md
Name: tournament_chooser_table

Overview:
- Fetch-side counterpart of the mem-stage tournament update logic.
- Holds a PC-indexed table of 2-bit chooser counters and reads the selector at fetch. Combines the selector with local/global counter predictions to produce the final taken/not-taken.
- Accepts the updated counter written back from mem.
- Maintains the speculative global history register (GHR) used by the global predictor, with repair on mispredict.

Parameters:
- INDEX_BITS, 6, table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2].
- GHR_BITS, 8, width of global history register.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- lookup_en  input  1  start lookup for lookup_pc this cycle
- lookup_stall  input  1  hold all fetch-side output registers
- lookup_pc  input  32  fetch PC
- pred_valid  output  1  pred_sel valid (one cycle after lookup_en)
- pred_sel  output  2  chooser counter read for the looked-up PC
- pred_local  input  2  local counter, aligned with pred_valid cycle
- pred_global  input  2  global counter, aligned with pred_valid cycle
- pred_taken  output  1  final prediction
- spec_shift_en  input  1  shift speculative outcome into GHR
- spec_taken  input  1  speculative outcome bit
- load_prediction  input  1  write update_sel into table at update_pc
- update_pc  input  32  resolving branch PC
- update_sel  input  2  new chooser counter from mem-stage FSM
- repair_en  input  1  mispredict: restore GHR from checkpoint
- repair_ghr  input  GHR_BITS  GHR checkpoint carried with the branch
- repair_taken  input  1  actual outcome of the mispredicted branch
- ghr  output  GHR_BITS  current speculative history

Behaviour:
- Reset (async, rst=1):
  - All table entries = 2'b01 (weak local).
  - pred_valid = 0, pred_sel = 2'b01, ghr = 0.
  - Reset asserted mid-lookup discards the lookup; pred_valid is 0 in the first cycle after release.
- Lookup (registered read, 1-cycle latency):
  - On a posedge with lookup_en=1 and lookup_stall=0: pred_sel <= table[idx(lookup_pc)] and pred_valid <= 1.
  - With lookup_en=0 and lookup_stall=0: pred_valid <= 0 and pred_sel holds its value.
  - lookup_stall=1 freezes pred_valid and pred_sel regardless of lookup_en.
- Combination (combinational): pred_taken = pred_sel[1] ? pred_global[1] : pred_local[1], gated to 0 when pred_valid=0.
  - Selector encoding: 00 strong local, 01 weak local, 10 weak global, 11 strong global.
- Update:
  - On a posedge with load_prediction=1: table[idx(update_pc)] <= update_sel.
  - Writes are not blocked by lookup_stall.
  - Only one write port; the update always completes in the cycle it is presented.
- Simultaneous update and lookup to the same index in the same cycle: see Optional Feature.
- GHR:
  - spec_shift_en=1: ghr <= {ghr[GHR_BITS-2:0], spec_taken}.
  - repair_en=1: ghr <= {repair_ghr[GHR_BITS-2:0], repair_taken}.
  - repair_en and spec_shift_en in the same cycle: repair wins and the speculative shift is dropped.
  - Neither asserted: ghr holds.
- Index wrap: PCs differing only above bit INDEX_BITS+1 alias to the same entry. This is intended; there are no tags.

Optional Feature:
- Macro: TOURNAMENT_BYPASS_EN.
- Defined: if load_prediction=1 and idx(update_pc)==idx(lookup_pc) on a lookup edge, pred_sel captures update_sel (write-through bypass).
- Undefined: pred_sel captures the pre-write table value; the write still completes.

Test Plan:
- Reset, then lookup_en with pc=0x0000_0040 -> next cycle pred_valid=1 and pred_sel=01. With pred_local=2'b10 and pred_global=2'b00 -> pred_taken=1.
- load_prediction with update_pc=0x40, update_sel=11; later lookup pc=0x40 -> pred_sel=11. With pred_global=2'b10 and pred_local=2'b00 -> pred_taken=1. Lookup pc=0x140 (aliases with INDEX_BITS=6) -> pred_sel=11.
- Same-cycle update pc=0x80 sel=10 and lookup pc=0x80 (entry previously 01) -> pred_sel=10 with TOURNAMENT_BYPASS_EN, 01 without. The following lookup returns 10 in both builds.
- lookup_stall=1 for 3 cycles while lookup_en toggles with new PCs -> pred_valid and pred_sel unchanged. A load_prediction issued during the stall is visible after the stall releases.
- GHR, from ghr=0: shift taken=1,1,0 -> ghr=8'h06. Then repair_en=1 and spec_shift_en=1 in the same cycle with repair_ghr=8'hA5, repair_taken=0 -> ghr=8'h4A.
- Assert rst asynchronously mid-cycle after several updates -> ghr=0 and pred_valid=0 immediately. After release, lookup of every previously written index returns 01.
